pll_clkgen_param: RTL and testbench

- Parametrised successor to the team's simple divide-by-2 clock/reset generator for the VGA path.
- Produces a divided clock (`clkOut`) with a runtime-selectable ratio, plus a one-cycle clock-enable pulse aligned to `clkOut` rising edges.
- Produces a reset (`rstOut`) stretched over a programmable number of output periods, and a `locked` flag.
- On a ratio change it re-issues `rstOut` so downstream pixel logic restarts cleanly.

---
 rtl/vga_clk_pkg.sv | 16 +
 rtl/clk_div_core.sv | 54 +++++
 rtl/pll_clkgen_param.sv | 99 +++++++++
 tb/tb_pll_clkgen_param.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vga_clk_pkg.sv
// Shared types and helpers for the parametrised VGA clock/reset generator.
package vga_clk_pkg;

  typedef enum logic {
    STRETCH = 1'b0,
    RUN     = 1'b1
  } state_e;

  localparam logic [31:0] MIN_DIV = 32'd2;

  // Ratios below MIN_DIV cannot produce a real clock, so they collapse to it.
  function automatic logic [31:0] eff_div(input logic [31:0] sel);
    return (sel < MIN_DIV) ? MIN_DIV : sel;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and divided-clock generator; the ratio is only adopted at a
// period boundary so clkOut never produces a runt pulse on a ratio change.
module clk_div_core
  import vga_clk_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clkRef,
  input  logic             reset,
  input  logic [DIV_W-1:0] n_req,
  output logic             clk_out,
  output logic             clk_en,
  output logic             wrap,
  output logic             load,
  output logic [DIV_W-1:0] n_q
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_d;
  logic             run_q, run_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;

  always_comb begin
    wrap      = run_q && (cnt_q == n_q - DIV_W'(1));
    // The first edge after reset also starts a period, without being a wrap.
    load      = !run_q || wrap;
    run_d     = 1'b1;
    cnt_d     = load ? '0 : cnt_q + DIV_W'(1);
    n_d       = load ? n_req : n_q;
    clk_out_d = (cnt_d < (n_q >> 1));
    clk_en_d  = load;
  end

  always_ff @(posedge clkRef or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      n_q       <= DIV_W'(MIN_DIV);
      run_q     <= 1'b0;
      clk_out_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      run_q     <= run_d;
      clk_out_q <= clk_out_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign clk_out = clk_out_q;
  assign clk_en  = clk_en_q;

endmodule

// File: rtl/pll_clkgen_param.sv
// Divided VGA clock with a stretched reset that is re-issued whenever the
// requested ratio changes, plus a locked flag for the pixel domain.
module pll_clkgen_param
  import vga_clk_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic             clkRef,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_sel,
  output logic             clkOut,
  output logic             clkEn,
  output logic             rstOut,
  output logic             locked
);

  localparam logic [7:0] RST_INIT = 8'(RST_CYCLES);

  logic [DIV_W-1:0] n_eff, n_cur;
  logic             wrap, load, chg;
  state_e           state_q, state_d;
  logic [7:0]       stretch_q, stretch_d;
  logic             rst_q, rst_d;
  logic             lock_q, lock_d;

  assign n_eff = DIV_W'(eff_div(32'(div_sel)));

  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .clkRef  (clkRef),
    .reset   (reset),
    .n_req   (n_eff),
    .clk_out (clkOut),
    .clk_en  (clkEn),
    .wrap    (wrap),
    .load    (load),
    .n_q     (n_cur)
  );

  // Pending ratio change; it is acted on only at the wrap, so a request that
  // reverts before then leaves the running clock untouched.
  assign chg = (n_eff != n_cur);

  always_comb begin
    state_d   = state_q;
    stretch_d = stretch_q;
    rst_d     = rst_q;
    lock_d    = lock_q;
    case (state_q)
      STRETCH: begin
        rst_d  = 1'b1;
        lock_d = 1'b0;
        if (load && !wrap) begin
          stretch_d = RST_INIT;
        end else if (wrap) begin
          if (chg) begin
            stretch_d = RST_INIT;
          end else if (stretch_q <= 8'd1) begin
            stretch_d = 8'd0;
            state_d   = RUN;
            rst_d     = 1'b0;
            lock_d    = 1'b1;
          end else begin
            stretch_d = stretch_q - 8'd1;
          end
        end
      end
      RUN: begin
        rst_d  = 1'b0;
        lock_d = 1'b1;
        if (wrap && chg) begin
          state_d   = STRETCH;
          stretch_d = RST_INIT;
          rst_d     = 1'b1;
          lock_d    = 1'b0;
        end
      end
      default: state_d = STRETCH;
    endcase
  end

  always_ff @(posedge clkRef or posedge reset) begin
    if (reset) begin
      state_q   <= STRETCH;
      stretch_q <= RST_INIT;
      rst_q     <= 1'b1;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stretch_q <= stretch_d;
      rst_q     <= rst_d;
      lock_q    <= lock_d;
    end
  end

  assign rstOut = rst_q;
  assign locked = lock_q;

endmodule

// File: tb/tb_pll_clkgen_param.sv
// Directed bench for pll_clkgen_param; expected output tuples are
// {clkOut, clkEn, rstOut, locked} for the edge following each stimulus step.
module tb_pll_clkgen_param;

  logic       clkRef;
  logic       reset;
  logic [7:0] div_sel;
  logic       clkOut, clkEn, rstOut, locked;
  logic       rst_probe;

  logic [3:0] exp_q[$];
  logic [3:0] mon_e, mon_got;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  logic [3:0] t1 [12] = '{4'b1110, 4'b0010, 4'b1110, 4'b0010, 4'b1110, 4'b0010,
                          4'b1110, 4'b0010, 4'b1101, 4'b0001, 4'b1101, 4'b0001};

  pll_clkgen_param #(.DIV_W(8), .RST_CYCLES(4)) dut (
    .clkRef  (clkRef),
    .reset   (reset),
    .div_sel (div_sel),
    .clkOut  (clkOut),
    .clkEn   (clkEn),
    .rstOut  (rstOut),
    .locked  (locked)
  );

  initial clkRef = 1'b0;
  always #5 clkRef = ~clkRef;

  // Monitor: compares on every falling edge, and on rst_probe for the
  // asynchronous-reset check that must hold before any clock edge.
  always @(negedge clkRef or posedge rst_probe) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_got = {clkOut, clkEn, rstOut, locked};
      vec_cnt++;
      if (mon_got !== mon_e) begin
        err_cnt++;
        $display("FAIL outputs{clkOut,clkEn,rstOut,locked} at %0t: got %b expected %b",
                 $time, mon_got, mon_e);
      end
    end
  end

  task automatic step(input logic [3:0] e);
    exp_q.push_back(e);
    @(negedge clkRef);
    #1;
  endtask

  task automatic cyc_range(input int n, input int c0, input int c1, input logic [1:0] rl);
    for (int c = c0; c <= c1; c++)
      step({logic'(c < n / 2), logic'(c == 0), rl});
  endtask

  task automatic period(input int n, input logic [1:0] rl);
    cyc_range(n, 0, n - 1, rl);
  endtask

  // Reset just released: 4 stretched periods, then running periods.
  task automatic from_reset(input int n);
    repeat (4) period(n, 2'b10);
    repeat (2) period(n, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    div_sel   = 8'd2;
    rst_probe = 1'b0;
    @(negedge clkRef);
    #1;
    step(4'b0010);
    step(4'b0010);

    // Ratio 2 from reset: clkEn on cycles 1,3,5,7,9, release at cycle 9.
    reset = 1'b0;
    foreach (t1[i]) step(t1[i]);

    // Ratio 5 from reset: 2 high, 3 low.
    reset = 1'b1; div_sel = 8'd5;
    step(4'b0010);
    reset = 1'b0;
    from_reset(5);
    period(5, 2'b01);

    // Ratios 0 and 1 behave as 2; switching between them never re-locks.
    reset = 1'b1; div_sel = 8'd0;
    step(4'b0010);
    reset = 1'b0;
    from_reset(2);
    div_sel = 8'd1;
    repeat (3) period(2, 2'b01);
    div_sel = 8'd2;
    repeat (2) period(2, 2'b01);

    // Ratio 4, then request 6 at cnt=1: current period finishes, then re-lock.
    reset = 1'b1; div_sel = 8'd4;
    step(4'b0010);
    reset = 1'b0;
    from_reset(4);
    cyc_range(4, 0, 0, 2'b01);
    div_sel = 8'd6;
    cyc_range(4, 1, 3, 2'b01);
    repeat (4) period(6, 2'b10);
    repeat (2) period(6, 2'b01);

    // Back from 6 to 4.
    cyc_range(6, 0, 0, 2'b01);
    div_sel = 8'd4;
    cyc_range(6, 1, 5, 2'b01);
    repeat (4) period(4, 2'b10);
    period(4, 2'b01);

    // One-cycle pulse to 6 that reverts before the wrap: no re-lock.
    cyc_range(4, 0, 0, 2'b01);
    div_sel = 8'd6;
    cyc_range(4, 1, 1, 2'b01);
    div_sel = 8'd4;
    cyc_range(4, 2, 3, 2'b01);
    repeat (2) period(4, 2'b01);

    // Asynchronous reset mid-period in RUN takes effect without a clock edge.
    cyc_range(4, 0, 1, 2'b01);
    exp_q.push_back(4'b0010);
    reset = 1'b1;
    #1 rst_probe = 1'b1;
    if ({clkOut, clkEn, rstOut, locked} !== 4'b0010) begin
      err_cnt++;
      $display("FAIL async reset outputs at %0t: got %b expected 0010",
               $time, {clkOut, clkEn, rstOut, locked});
    end
    #1 rst_probe = 1'b0;
    step(4'b0010);
    step(4'b0010);
    reset = 1'b0;

    // Ratio change during STRETCH restarts the stretch at the wrap.
    repeat (2) period(4, 2'b10);
    cyc_range(4, 0, 0, 2'b10);
    div_sel = 8'd2;
    cyc_range(4, 1, 3, 2'b10);
    repeat (4) period(2, 2'b10);
    repeat (2) period(2, 2'b01);

    if ({rstOut, locked} !== 2'b01) begin
      err_cnt++;
      $display("FAIL final lock state: rstOut=%b locked=%b", rstOut, locked);
    end
    if (exp_q.size() != 0 || vec_cnt == 0) begin
      err_cnt++;
      $display("FAIL scoreboard: %0d expectations left, %0d compared",
               exp_q.size(), vec_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
